addsub_arbiter_seq: RTL and testbench
=====================================

Name: addsub_arbiter_seq

Overview:
Serialised 32-bit add/subtract engine with a built-in arbiter.
- One internal HALF-width add slice is shared in time between two requesters.
- Each operation runs low half first, then high half. The carry between halves is held in a register.
- Sits between two client blocks and a single response consumer. It trades throughput for half the adder area of a full-width add/sub.

Parameters:
WIDTH, 32, operand/result width; must be even and >= 4
HALF, WIDTH/2, derived slice width; not overridable

Ports:
clk  in  1  rising-edge clock
resetn  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle
req0_a  in  WIDTH  requester 0 operand a
req0_b  in  WIDTH  requester 0 operand b
req0_sub  in  1  requester 0: 1 = a-b, 0 = a+b
req1_valid  in  1  requester 1 has an operation
req1_ready  out  1  requester 1 operation accepted this cycle
req1_a  in  WIDTH  requester 1 operand a
req1_b  in  WIDTH  requester 1 operand b
req1_sub  in  1  requester 1: 1 = a-b, 0 = a+b
rsp_valid  out  1  result available
rsp_ready  in  1  consumer takes result
rsp_sum  out  WIDTH  result
rsp_cout  out  1  carry out of MSB; for subtract, 1 = no borrow
rsp_ovf  out  1  two's-complement signed overflow
rsp_id  out  1  requester that issued the result

Behaviour:
- States: IDLE, LO, HI, DONE. Registered state.
- IDLE:
  - If any reqX_valid is high, grant one requester and assert its reqX_ready combinationally (same cycle).
  - Latch a, b^{WIDTH{sub}}, sub and id. Go to LO.
  - reqX_ready is high only when state == IDLE and X is granted. Never more than one ready at a time.
- Arbitration:
  - Only one valid: that requester wins.
  - Both valid: the requester not served last wins.
  - The last-served pointer updates on each accept. It resets to 1, so req0 wins the first contention after reset.
- LO: low slice computes a[HALF-1:0] + b_eff[HALF-1:0] + sub. Register the low sum and the carry. Go to HI.
- HI:
  - High slice computes a[WIDTH-1:HALF] + b_eff[WIDTH-1:HALF] + carry_lo.
  - Register the high sum, cout and ovf. ovf = carry into MSB XOR carry out of MSB.
  - Go to DONE.
- DONE:
  - rsp_valid = 1. rsp_sum/rsp_cout/rsp_ovf/rsp_id are stable.
  - When rsp_ready is high, go to IDLE next edge.
  - While stalled, hold all response outputs and accept no requests.
- Latency and throughput:
  - Accept edge N gives rsp_valid high after edge N+2 (3rd cycle after the accept cycle).
  - Minimum 4 cycles per operation. A new accept is possible in the cycle after rsp handshake.
- Response outputs are registered, with no combinational path from req inputs.
- Arithmetic is modulo 2^WIDTH; there is no saturation.
- Requester inputs are sampled only at the accept edge. Changes after accept do not affect the in-flight operation.
- A requester deasserting valid before ready is allowed. It is simply not granted.
- Reset (resetn low, any state, including mid-operation):
  - Immediately: state = IDLE, rsp_valid = 0, rsp_sum = 0, rsp_cout = 0, rsp_ovf = 0, rsp_id = 0, both ready = 0 while in reset.
  - Last-served pointer = 1.
  - The in-flight operation is discarded and never responded to.

Test Plan:
- Basic add: req0 a=0x0000FFFF, b=0x00000001, sub=0 -> carry crosses the half boundary; rsp_sum=0x00010000, cout=0, ovf=0, id=0; rsp_valid 3 cycles after accept.
- Subtract: req1 a=5, b=7, sub=1 -> rsp_sum=0xFFFFFFFE, cout=0, ovf=0, id=1. Then a=7, b=5 -> sum=2, cout=1.
- Overflow: add 0x7FFFFFFF+1 -> 0x80000000, ovf=1, cout=0. Subtract 0x80000000-1 -> 0x7FFFFFFF, ovf=1, cout=1. Add 0xFFFFFFFF+1 -> 0, cout=1, ovf=0.
- Contention: both valid continuously from reset, rsp_ready=1 -> grants alternate 0,1,0,1; one ready per 4 cycles; never both high.
- Back-pressure: rsp_ready=0 for 5 cycles in DONE -> rsp fields unchanged, both reqX_ready=0. Release -> IDLE next edge, accept on the following cycle.
- Reset mid-op: drop resetn during HI -> rsp_valid=0 and all outputs 0 immediately. After release, both valid -> req0 granted first; no stale response appears.

Source files
------------

// File: rtl/addsub_arbiter_seq.sv
// addsub_arbiter_seq: two-requester add/subtract engine that reuses one
// half-width adder slice over two cycles (low half, then high half), with a
// round-robin arbiter in front and a registered response port behind.
module addsub_arbiter_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_sub,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_sub,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout,
    output logic             rsp_ovf,
    output logic             rsp_id
);

    localparam int HALF = WIDTH / 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Latched operation (b is stored already inverted for subtract)
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b_eff;
    logic             r_sub;
    logic             r_id;
    logic             r_last;      // requester served most recently
    logic             r_carry;     // carry from low half into high half
    logic [HALF-1:0]  r_sum_lo;

    // Response registers
    logic             r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_sum;
    logic             r_rsp_cout;
    logic             r_rsp_ovf;
    logic             r_rsp_id;

    // Arbiter / capture wires
    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_accept;
    logic [WIDTH-1:0] w_in_a;
    logic [WIDTH-1:0] w_in_b;
    logic             w_in_sub;

    // Shared slice wires
    logic [HALF-1:0]  w_op_a;
    logic [HALF-1:0]  w_op_b;
    logic             w_cin;
    logic [HALF:0]    w_slice;
    logic             w_msb_cin;

    // State register; reset discards any in-flight operation
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and grant: ready only in IDLE, out of reset, to one winner
    always_comb begin
        w_state_nxt = r_state;
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (resetn && req0_valid && req1_valid) begin
                    // Contention: the requester not served last wins
                    if (r_last) begin
                        w_gnt0 = 1'b1;
                    end else begin
                        w_gnt1 = 1'b1;
                    end
                end else if (resetn && req0_valid) begin
                    w_gnt0 = 1'b1;
                end else if (resetn && req1_valid) begin
                    w_gnt1 = 1'b1;
                end else begin
                    w_gnt0 = 1'b0;
                    w_gnt1 = 1'b0;
                end
                if (w_gnt0 || w_gnt1) begin
                    w_state_nxt = ST_LO;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_LO:   w_state_nxt = ST_HI;
            ST_HI:   w_state_nxt = ST_DONE;
            ST_DONE: begin
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_accept   = w_gnt0 | w_gnt1;
    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;

    // Select the granted requester's operands for capture
    always_comb begin
        if (w_gnt1) begin
            w_in_a   = req1_a;
            w_in_b   = req1_b;
            w_in_sub = req1_sub;
        end else begin
            w_in_a   = req0_a;
            w_in_b   = req0_b;
            w_in_sub = req0_sub;
        end
    end

    // Capture the operation on accept; inputs are ignored afterwards
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_a     <= {WIDTH{1'b0}};
            r_b_eff <= {WIDTH{1'b0}};
            r_sub   <= 1'b0;
            r_id    <= 1'b0;
            r_last  <= 1'b1;
        end else if (w_accept) begin
            r_a     <= w_in_a;
            r_b_eff <= w_in_b ^ {WIDTH{w_in_sub}};
            r_sub   <= w_in_sub;
            r_id    <= w_gnt1;
            r_last  <= w_gnt1;
        end else begin
            r_last  <= r_last;
        end
    end

    // Shared slice operand mux: high half in HI (carry_lo in), else low half (sub in)
    always_comb begin
        if (r_state == ST_HI) begin
            w_op_a = r_a[WIDTH-1:HALF];
            w_op_b = r_b_eff[WIDTH-1:HALF];
            w_cin  = r_carry;
        end else begin
            w_op_a = r_a[HALF-1:0];
            w_op_b = r_b_eff[HALF-1:0];
            w_cin  = r_sub;
        end
    end

    assign w_slice   = {1'b0, w_op_a} + {1'b0, w_op_b} + {{HALF{1'b0}}, w_cin};
    // Carry into the slice MSB, recovered from the MSB sum bit
    assign w_msb_cin = w_op_a[HALF-1] ^ w_op_b[HALF-1] ^ w_slice[HALF-1];

    // Hold the low half result and the inter-half carry
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sum_lo <= {HALF{1'b0}};
            r_carry  <= 1'b0;
        end else if (r_state == ST_LO) begin
            r_sum_lo <= w_slice[HALF-1:0];
            r_carry  <= w_slice[HALF];
        end else begin
            r_carry  <= r_carry;
        end
    end

    // Response registers: loaded in HI, held through DONE, valid cleared on handshake
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rsp_valid <= 1'b0;
            r_rsp_sum   <= {WIDTH{1'b0}};
            r_rsp_cout  <= 1'b0;
            r_rsp_ovf   <= 1'b0;
            r_rsp_id    <= 1'b0;
        end else begin
            case (r_state)
                ST_HI: begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_sum   <= {w_slice[HALF-1:0], r_sum_lo};
                    r_rsp_cout  <= w_slice[HALF];
                    r_rsp_ovf   <= w_slice[HALF] ^ w_msb_cin;
                    r_rsp_id    <= r_id;
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                    end else begin
                        r_rsp_valid <= 1'b1;
                    end
                end
                default: r_rsp_valid <= r_rsp_valid;
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_sum   = r_rsp_sum;
    assign rsp_cout  = r_rsp_cout;
    assign rsp_ovf   = r_rsp_ovf;
    assign rsp_id    = r_rsp_id;

endmodule

// File: tb/tb_addsub_arbiter_seq.sv
// Self-checking bench for addsub_arbiter_seq: scoreboard of expected
// responses computed from a 33-bit reference model and a bench-side arbiter.
module tb_addsub_arbiter_seq;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req0_valid, req0_ready, req0_sub;
    logic [31:0] req0_a, req0_b;
    logic        req1_valid, req1_ready, req1_sub;
    logic [31:0] req1_a, req1_b;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_sum;
    logic        rsp_cout, rsp_ovf, rsp_id;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        id;
    } rsp_t;

    rsp_t sb_q[$];
    logic tb_last;   // bench model of the last-served pointer

    always #5 clk = ~clk;

    addsub_arbiter_seq #(.WIDTH(32)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_sub   (req0_sub),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_sub   (req1_sub),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_sum    (rsp_sum),
        .rsp_cout   (rsp_cout),
        .rsp_ovf    (rsp_ovf),
        .rsp_id     (rsp_id)
    );

    function automatic rsp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic sub, input logic id);
        rsp_t        r;
        logic [32:0] full;
        full   = sub ? ({1'b0, a} - {1'b0, b} + 33'h100000000) : ({1'b0, a} + {1'b0, b});
        r.sum  = full[31:0];
        r.cout = full[32];
        if (sub) r.ovf = (a[31] != b[31]) && (full[31] != a[31]);
        else     r.ovf = (a[31] == b[31]) && (full[31] != a[31]);
        r.id   = id;
        return r;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic [31:0] a, input logic [31:0] b, input logic sub);
        if (r == 0) begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sub = sub;
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sub = sub;
        end
    endtask

    // Called just after the accept edge; waits for the response and scores it
    task automatic expect_response(input string tag, input int exp_lat, output rsp_t e);
        int   k;
        rsp_t got;
        k = 0;
        e = '0;
        while (!rsp_valid && k < 12) begin
            cyc();
            k++;
        end
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: rsp_valid=%b after %0d cycles, required 1", tag, rsp_valid, k);
            return;
        end
        checks++;
        if (k != exp_lat) begin
            errors++;
            $display("FAIL %s_latency: got %0d cycles, required %0d", tag, k, exp_lat);
        end
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL %s_unexpected: response with no expected entry", tag);
        end else begin
            e   = sb_q.pop_front();
            got = {rsp_sum, rsp_cout, rsp_ovf, rsp_id};
            if (got !== e) begin
                errors++;
                $display("FAIL %s_data: got sum=%h cout=%b ovf=%b id=%b, required sum=%h cout=%b ovf=%b id=%b",
                         tag, rsp_sum, rsp_cout, rsp_ovf, rsp_id, e.sum, e.cout, e.ovf, e.id);
            end
        end
    endtask

    // One isolated operation from requester r with rsp_ready high
    task automatic run_op(input string tag, input int r, input logic [31:0] a,
                          input logic [31:0] b, input logic sub);
        rsp_t e;
        logic rdy_me, rdy_other;
        set_req(r, a, b, sub);
        #1;
        rdy_me    = (r == 0) ? req0_ready : req1_ready;
        rdy_other = (r == 0) ? req1_ready : req0_ready;
        checks++;
        if (rdy_me !== 1'b1 || rdy_other !== 1'b0) begin
            errors++;
            $display("FAIL %s_grant: got ready_me=%b ready_other=%b, required 1/0", tag, rdy_me, rdy_other);
        end
        sb_q.push_back(model(a, b, sub, r[0]));
        tb_last = r[0];
        cyc();
        // Operands change after accept and must not disturb the operation
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = $urandom; req0_b = $urandom; req1_a = $urandom; req1_b = $urandom;
        req0_sub = ~req0_sub; req1_sub = ~req1_sub;
        expect_response(tag, 2, e);
        cyc();
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_release: rsp_valid=%b after handshake, required 0", tag, rsp_valid);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; rsp_ready = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = 32'd0; req0_b = 32'd0; req0_sub = 1'b0;
        req1_a = 32'd0; req1_b = 32'd0; req1_sub = 1'b0;
        cyc(); cyc();
        checks++;
        if ({rsp_valid, rsp_sum, rsp_cout, rsp_ovf, rsp_id} !== 36'd0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got valid=%b sum=%h cout=%b ovf=%b id=%b rdy=%b%b, required all 0",
                     rsp_valid, rsp_sum, rsp_cout, rsp_ovf, rsp_id, req0_ready, req1_ready);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        resetn = 1'b1;
        tb_last = 1'b1;
        cyc();
    endtask

    task automatic test_contention();
        int   nacc, nrsp, last_acc, w;
        logic exp_w;
        rsp_t e, got;
        resetn = 1'b0; cyc(); resetn = 1'b1;
        tb_last = 1'b1;
        rsp_ready = 1'b1;
        set_req(0, $urandom, $urandom, 1'b0);
        set_req(1, $urandom, $urandom, 1'b1);
        #1;
        nacc = 0; nrsp = 0; last_acc = -1; w = -1;
        for (int c = 0; c < 60 && nrsp < 4; c++) begin
            if (rsp_valid) begin
                checks++;
                got = {rsp_sum, rsp_cout, rsp_ovf, rsp_id};
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL cont_unexpected: response with no expected entry");
                end else begin
                    e = sb_q.pop_front();
                    if (got !== e) begin
                        errors++;
                        $display("FAIL cont_data: got sum=%h cout=%b ovf=%b id=%b, required sum=%h cout=%b ovf=%b id=%b",
                                 rsp_sum, rsp_cout, rsp_ovf, rsp_id, e.sum, e.cout, e.ovf, e.id);
                    end
                end
                nrsp++;
            end
            checks++;
            if (req0_ready && req1_ready) begin
                errors++;
                $display("FAIL cont_onehot: both readies high at cycle %0d", c);
            end
            w = -1;
            if (req0_ready || req1_ready) begin
                exp_w = ~tb_last;
                w     = req1_ready ? 1 : 0;
                checks++;
                if (w[0] !== exp_w) begin
                    errors++;
                    $display("FAIL cont_order: got grant %0d, required %0d", w, exp_w);
                end
                if (last_acc >= 0) begin
                    checks++;
                    if (c - last_acc != 4) begin
                        errors++;
                        $display("FAIL cont_spacing: got %0d cycles between accepts, required 4", c - last_acc);
                    end
                end
                if (w == 0) sb_q.push_back(model(req0_a, req0_b, req0_sub, 1'b0));
                else        sb_q.push_back(model(req1_a, req1_b, req1_sub, 1'b1));
                tb_last  = w[0];
                last_acc = c;
                nacc++;
            end
            cyc();
            if (w == 0) begin req0_a = $urandom; req0_b = $urandom; req0_sub = ~req0_sub; end
            if (w == 1) begin req1_a = $urandom; req1_b = $urandom; req1_sub = ~req1_sub; end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        checks++;
        if (nrsp != 4 || nacc != 4) begin
            errors++;
            $display("FAIL cont_count: got %0d accepts %0d responses, required 4/4", nacc, nrsp);
        end
        cyc();
    endtask

    task automatic test_basic_add();
        run_op("add_carry_half", 0, 32'h0000FFFF, 32'h00000001, 1'b0);
    endtask

    task automatic test_subtract();
        run_op("sub_borrow", 1, 32'd5, 32'd7, 1'b1);
        run_op("sub_noborrow", 1, 32'd7, 32'd5, 1'b1);
    endtask

    task automatic test_overflow();
        run_op("ovf_add_pos", 0, 32'h7FFFFFFF, 32'h00000001, 1'b0);
        run_op("ovf_sub_neg", 1, 32'h80000000, 32'h00000001, 1'b1);
        run_op("wrap_add", 0, 32'hFFFFFFFF, 32'h00000001, 1'b0);
    endtask

    task automatic test_backpressure();
        rsp_t e, got;
        rsp_ready = 1'b0;
        set_req(0, 32'h12345678, 32'h11111111, 1'b0);
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_grant: got req0_ready=%b, required 1", req0_ready);
        end
        sb_q.push_back(model(32'h12345678, 32'h11111111, 1'b0, 1'b0));
        tb_last = 1'b0;
        cyc();
        set_req(0, $urandom, $urandom, 1'b1);
        set_req(1, $urandom, $urandom, 1'b0);
        expect_response("bp", 2, e);
        for (int i = 0; i < 5; i++) begin
            got = {rsp_sum, rsp_cout, rsp_ovf, rsp_id};
            checks++;
            if (got !== e || rsp_valid !== 1'b1 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold: cycle %0d got valid=%b sum=%h rdy=%b%b, required 1 sum=%h rdy=00",
                         i, rsp_valid, rsp_sum, req0_ready, req1_ready, e.sum);
            end
            cyc();
        end
        rsp_ready = 1'b1;
        cyc();
        checks++;
        if (rsp_valid !== 1'b0 || req1_ready !== ~tb_last || req0_ready !== tb_last) begin
            errors++;
            $display("FAIL bp_release: got valid=%b rdy0=%b rdy1=%b, required 0/%b/%b",
                     rsp_valid, req0_ready, req1_ready, tb_last, ~tb_last);
        end
        sb_q.push_back(model(req1_a, req1_b, req1_sub, 1'b1));
        tb_last = 1'b1;
        cyc();
        req0_valid = 1'b0; req1_valid = 1'b0;
        expect_response("bp_next", 2, e);
        cyc();
    endtask

    task automatic test_reset_midop();
        rsp_t e;
        set_req(0, 32'hDEADBEEF, 32'h01010101, 1'b0);
        #1;
        cyc();                          // accepted, not scoreboarded: it will be killed
        req0_valid = 1'b0;
        tb_last = 1'b0;
        cyc();                          // now in HI
        set_req(0, 32'h00000100, 32'h00000023, 1'b1);
        set_req(1, 32'h00000001, 32'h00000002, 1'b0);
        resetn = 1'b0;
        #1;
        checks++;
        if ({rsp_valid, rsp_sum, rsp_cout, rsp_ovf, rsp_id} !== 36'd0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL midop_reset: got valid=%b sum=%h cout=%b ovf=%b id=%b rdy=%b%b, required all 0",
                     rsp_valid, rsp_sum, rsp_cout, rsp_ovf, rsp_id, req0_ready, req1_ready);
        end
        cyc();
        resetn = 1'b1;
        tb_last = 1'b1;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL midop_first_grant: got rdy0=%b rdy1=%b valid=%b, required 1/0/0",
                     req0_ready, req1_ready, rsp_valid);
        end
        sb_q.push_back(model(32'h00000100, 32'h00000023, 1'b1, 1'b0));
        tb_last = 1'b0;
        cyc();
        req0_valid = 1'b0; req1_valid = 1'b0;
        expect_response("midop_post", 2, e);
        cyc();
        checks++;
        if (sb_q.size() != 0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL final_drain: got %0d pending, valid=%b, required 0/0", sb_q.size(), rsp_valid);
        end
    endtask

    initial begin
        test_reset();
        test_contention();
        test_basic_add();
        test_subtract();
        test_overflow();
        test_backpressure();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
